// File: rtl/fb_mem_dp.sv
// Dual-port frame buffer. The host port does masked read/write with a ready handshake.
// The video port is read-only and never stalls. The fill engine paints every word with one value.
module fb_mem_dp #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4800,
    parameter int ADDR_W  = 13,
    parameter int VID_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_host_req,
    input  logic              i_host_wen,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    input  logic [DATA_W-1:0] i_host_wmask,
    output logic              o_host_ready,
    output logic              o_host_rvalid,
    output logic [DATA_W-1:0] o_host_rdata,
    input  logic              i_vid_ren,
    input  logic [ADDR_W-1:0] i_vid_addr,
    output logic              o_vid_rvalid,
    output logic [DATA_W-1:0] o_vid_rdata,
    input  logic              i_fill_start,
    input  logic [DATA_W-1:0] i_fill_data,
    output logic              o_fill_busy,
    output logic              o_fill_done
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, FILL} state_t;
    state_t state, state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] fill_val;
    logic              fill_last;
    logic              host_xfer;
    logic              host_rd;
    logic              host_we;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;

    assign fill_last = (state == FILL) && (cnt == LAST);
    assign host_xfer = i_host_req && o_host_ready;
    assign host_rd   = host_xfer && !i_host_wen;
    assign host_we   = host_xfer && i_host_wen && (i_host_addr <= LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            fill_val    <= '0;
            o_fill_done <= 1'b0;
        end else begin
            state       <= state_next;
            o_fill_done <= fill_last;
            if (state == IDLE && i_fill_start) begin
                cnt      <= '0;
                fill_val <= i_fill_data;
            end else if (state == FILL) begin
                cnt <= fill_last ? '0 : cnt + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_fill_start) state_next = FILL;
            FILL:    if (fill_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ready is gated by reset so that every output reads 0 while rst_n is low.
    always_comb begin
        o_fill_busy  = (state == FILL);
        o_host_ready = rst_n && (state == IDLE) && !i_fill_start;
    end

    // Host writes only happen in IDLE, so they never collide with fill writes.
    always_ff @(posedge clk) begin
        if (state == FILL)
            mem[cnt] <= fill_val;
        else if (host_we)
            mem[i_host_addr] <= (mem[i_host_addr] & ~i_host_wmask) | (i_host_wdata & i_host_wmask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_host_rvalid <= 1'b0;
            o_host_rdata  <= '0;
            vid_valid     <= 1'b0;
            vid_data      <= '0;
        end else begin
            o_host_rvalid <= host_rd;
            if (host_rd)
                o_host_rdata <= (i_host_addr <= LAST) ? mem[i_host_addr] : '0;
            vid_valid <= i_vid_ren;
            if (i_vid_ren)
                vid_data <= (i_vid_addr <= LAST) ? mem[i_vid_addr] : '0;
        end
    end

    generate
        if (VID_LAT == 2) begin : g_lat2
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o_vid_rvalid <= 1'b0;
                    o_vid_rdata  <= '0;
                end else begin
                    o_vid_rvalid <= vid_valid;
                    o_vid_rdata  <= vid_data;
                end
            end
        end else begin : g_lat1
            always_comb begin
                o_vid_rvalid = vid_valid;
                o_vid_rdata  = vid_data;
            end
        end
    endgenerate

endmodule

// File: tb/tb_fb_mem_dp.sv
// Bench for fb_mem_dp: two instances (video latency 2 and 1) share one stimulus stream.
// Expected read data comes from a reference memory and is queued with a due cycle.
module tb_fb_mem_dp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        host_req = 1'b0, host_wen = 1'b0;
    logic [12:0] host_addr = '0;
    logic [7:0]  host_wdata = '0, host_wmask = '0;
    logic        vid_ren = 1'b0;
    logic [12:0] vid_addr = '0;
    logic        fill_start = 1'b0;
    logic [7:0]  fill_data = '0;

    logic        host_ready, host_rvalid, vid_rvalid, fill_busy, fill_done;
    logic [7:0]  host_rdata, vid_rdata;
    logic        host_ready1, host_rvalid1, vid_rvalid1, fill_busy1, fill_done1;
    logic [7:0]  host_rdata1, vid_rdata1;

    fb_mem_dp #(.DATA_W(8), .DEPTH(4800), .ADDR_W(13), .VID_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_host_req(host_req), .i_host_wen(host_wen), .i_host_addr(host_addr),
        .i_host_wdata(host_wdata), .i_host_wmask(host_wmask),
        .o_host_ready(host_ready), .o_host_rvalid(host_rvalid), .o_host_rdata(host_rdata),
        .i_vid_ren(vid_ren), .i_vid_addr(vid_addr),
        .o_vid_rvalid(vid_rvalid), .o_vid_rdata(vid_rdata),
        .i_fill_start(fill_start), .i_fill_data(fill_data),
        .o_fill_busy(fill_busy), .o_fill_done(fill_done)
    );

    fb_mem_dp #(.DATA_W(8), .DEPTH(4800), .ADDR_W(13), .VID_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_host_req(host_req), .i_host_wen(host_wen), .i_host_addr(host_addr),
        .i_host_wdata(host_wdata), .i_host_wmask(host_wmask),
        .o_host_ready(host_ready1), .o_host_rvalid(host_rvalid1), .o_host_rdata(host_rdata1),
        .i_vid_ren(vid_ren), .i_vid_addr(vid_addr),
        .o_vid_rvalid(vid_rvalid1), .o_vid_rdata(vid_rdata1),
        .i_fill_start(fill_start), .i_fill_data(fill_data),
        .o_fill_busy(fill_busy1), .o_fill_done(fill_done1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [7:0]  data;
    } exp_t;

    exp_t        hq[$], vq2[$], vq1[$];
    logic [7:0]  mdl [4800];
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mread(input logic [12:0] a);
        return (a < 13'd4800) ? mdl[a] : 8'h00;
    endfunction

    // Each port: rvalid must be high exactly on the due cycle of the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            logic ev;
            ev = (hq.size() > 0) && (hq[0].due == cyc);
            chk("host_rvalid", {7'b0, host_rvalid}, {7'b0, ev});
            if (ev) begin
                chk("host_rdata", host_rdata, hq[0].data);
                void'(hq.pop_front());
            end
            ev = (vq2.size() > 0) && (vq2[0].due == cyc);
            chk("vid2_rvalid", {7'b0, vid_rvalid}, {7'b0, ev});
            if (ev) begin
                chk("vid2_rdata", vid_rdata, vq2[0].data);
                void'(vq2.pop_front());
            end
            ev = (vq1.size() > 0) && (vq1[0].due == cyc);
            chk("vid1_rvalid", {7'b0, vid_rvalid1}, {7'b0, ev});
            if (ev) begin
                chk("vid1_rdata", vid_rdata1, vq1[0].data);
                void'(vq1.pop_front());
            end
        end
    end

    // Called just after a posedge; drives one cycle and returns just after the next posedge.
    task automatic step(input bit h, input bit w, input logic [12:0] a, input logic [7:0] d,
                        input logic [7:0] m, input bit v, input logic [12:0] va);
        host_req = h; host_wen = w; host_addr = a; host_wdata = d; host_wmask = m;
        vid_ren = v; vid_addr = va;
        if (v) begin
            vq2.push_back('{due: cyc + 2, data: mread(va)});
            vq1.push_back('{due: cyc + 1, data: mread(va)});
        end
        if (h) begin
            @(negedge clk);
            chk("host_ready", {7'b0, host_ready}, 8'h01);
            if (!w) hq.push_back('{due: cyc + 1, data: mread(a)});
            else if (a < 13'd4800) mdl[a] = (mdl[a] & ~m) | (d & m);
        end
        @(posedge clk); #1;
        host_req = 1'b0; host_wen = 1'b0; vid_ren = 1'b0;
    endtask

    initial begin
        int busy_cnt, done_cnt;
        bit accepted;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {7'b0, host_ready}, 8'h00);
        chk("rst_rvalid", {7'b0, host_rvalid}, 8'h00);
        chk("rst_rdata", host_rdata, 8'h00);
        chk("rst_vid_rvalid", {7'b0, vid_rvalid}, 8'h00);
        chk("rst_vid_rdata", vid_rdata, 8'h00);
        chk("rst_vid1_rdata", vid_rdata1, 8'h00);
        chk("rst_busy", {7'b0, fill_busy}, 8'h00);
        chk("rst_done", {7'b0, fill_done}, 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full-mask write then readback, then partial-mask merge.
        step(1, 1, 13'd100, 8'hA5, 8'hFF, 0, '0);
        step(1, 0, 13'd100, 8'h00, 8'h00, 0, '0);
        step(1, 1, 13'd100, 8'h0F, 8'h0F, 0, '0);
        step(1, 0, 13'd100, 8'h00, 8'h00, 1, 13'd100);

        // Fill start collides with a host read; fill wins, read lands on the first idle cycle.
        fill_start = 1'b1; fill_data = 8'h3C;
        host_req = 1'b1; host_wen = 1'b0; host_addr = 13'd100;
        @(negedge clk);
        chk("fill_start_ready", {7'b0, host_ready}, 8'h00);
        for (int i = 0; i < 4800; i++) mdl[i] = 8'h3C;
        @(posedge clk); #1;
        fill_start = 1'b0;
        busy_cnt = 0; done_cnt = 0; accepted = 0;
        for (int i = 0; i < 6000 && !accepted; i++) begin
            @(negedge clk);
            if (fill_busy) busy_cnt++;
            if (fill_done) done_cnt++;
            if (host_ready) begin
                chk("ready_on_done", {7'b0, fill_done}, 8'h01);
                hq.push_back('{due: cyc + 1, data: mread(13'd100)});
                accepted = 1;
            end
        end
        @(posedge clk); #1;
        host_req = 1'b0;
        chk("fill_accepted", {7'b0, accepted}, 8'h01);
        chk("fill_busy_cycles_lo", busy_cnt[7:0], 8'(4800 & 255));
        chk("fill_busy_cycles_hi", busy_cnt[15:8], 8'(4800 >> 8));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (fill_done) done_cnt++;
        end
        chk("fill_done_pulses", done_cnt[7:0], 8'h01);
        @(posedge clk); #1;

        step(0, 0, '0, '0, '0, 1, 13'd0);
        step(0, 0, '0, '0, '0, 1, 13'd2400);
        step(0, 0, '0, '0, '0, 1, 13'd4799);

        // Read-first: video read of 7 on the same edge as a host write to 7.
        step(1, 1, 13'd7, 8'h11, 8'hFF, 0, '0);
        step(1, 1, 13'd7, 8'h55, 8'hFF, 1, 13'd7);
        step(0, 0, '0, '0, '0, 1, 13'd7);
        step(1, 0, 13'd7, 8'h00, 8'h00, 0, '0);

        // Out of range address.
        step(1, 1, 13'd4800, 8'h12, 8'hFF, 0, '0);
        step(1, 0, 13'd4800, 8'h00, 8'h00, 1, 13'd4800);
        step(1, 0, 13'd4799, 8'h00, 8'h00, 1, 13'd8191);

        // Reset partway through a second fill.
        step(1, 1, 13'd1000, 8'h77, 8'hFF, 0, '0);
        repeat (4) @(posedge clk);
        #1;
        fill_start = 1'b1; fill_data = 8'hC3;
        @(posedge clk); #1;
        fill_start = 1'b0;
        chk("fill2_busy", {7'b0, fill_busy}, 8'h01);
        repeat (1000) @(posedge clk);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 1000; i++) mdl[i] = 8'hC3;
        #1;
        chk("abort_busy", {7'b0, fill_busy}, 8'h00);
        chk("abort_done", {7'b0, fill_done}, 8'h00);
        done_cnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (fill_done || fill_busy) done_cnt++;
        end
        chk("abort_no_done", done_cnt[7:0], 8'h00);
        @(posedge clk); #1;
        step(1, 0, 13'd0, 8'h00, 8'h00, 1, 13'd999);
        step(1, 0, 13'd999, 8'h00, 8'h00, 1, 13'd1000);
        step(1, 0, 13'd1000, 8'h00, 8'h00, 1, 13'd1001);
        step(1, 0, 13'd1001, 8'h00, 8'h00, 0, '0);
        repeat (4) @(posedge clk);
        #1;

        chk("host_queue_drained", 8'(hq.size()), 8'h00);
        chk("vid2_queue_drained", 8'(vq2.size()), 8'h00);
        chk("vid1_queue_drained", 8'(vq1.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
